saf_sweep_ctrl: RTL and testbench

SAF_SWEEP_CTRL -- requirements
Module: saf_sweep_ctrl

---
 rtl/saf_sweep_ctrl.sv | 140 ++++++++++++++
 tb/tb_saf_sweep_ctrl.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/saf_sweep_ctrl.sv
// Single stuck-at fault sweep controller: drives a CUT and its golden model
// with every pattern under every input stuck-at fault and records detections.
module saf_sweep_ctrl #(
  parameter int unsigned N_IN           = 2,
  parameter bit          STOP_ON_DETECT = 1'b0,
  localparam int unsigned NF = 2 * N_IN,
  localparam int unsigned FW = $clog2(NF),
  localparam int unsigned CW = $clog2(NF + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            cut_y,
  input  logic            gold_y,
  output logic [N_IN-1:0] cut_in,
  output logic [N_IN-1:0] gold_in,
  output logic            busy,
  output logic            done,
  output logic [FW-1:0]   fault_idx,
  output logic            detect_valid,
  output logic [N_IN-1:0] detect_pattern,
  output logic [NF-1:0]   detected_mask,
  output logic [CW-1:0]   coverage_cnt
);

  localparam int unsigned PW     = N_IN + 1;
  localparam logic [PW-1:0] P_LAST = {1'b0, {N_IN{1'b1}}};
  localparam logic [FW-1:0] F_LAST = FW'(NF - 1);

  typedef enum logic [1:0] {IDLE, APPLY, CHECK, DONE} state_t;

  state_t          state_q, state_d;
  logic [FW-1:0]   f_q, f_d;
  logic [PW-1:0]   p_q, p_d;
  logic [NF-1:0]   mask_q, mask_d;
  logic [CW-1:0]   cov_q, cov_d;
  logic [N_IN-1:0] cut_q, cut_d;
  logic [N_IN-1:0] gold_q, gold_d;
  logic            mismatch;
  logic            detect;
  logic            stop;

  function automatic logic [N_IN-1:0] inject(input logic [N_IN-1:0] pat,
                                             input logic [FW-1:0]   f);
    logic [N_IN-1:0] r;
    r = pat;
    for (int unsigned i = 0; i < N_IN; i++) begin
      if (i == 32'(f >> 1)) r[i] = f[0];
    end
    return r;
  endfunction

  // 4-state compare so an unknown response is treated as a detection
  assign mismatch = (cut_y !== gold_y);

  always_comb begin
    state_d = state_q;
    f_d     = f_q;
    p_d     = p_q;
    mask_d  = mask_q;
    cov_d   = cov_q;
    cut_d   = cut_q;
    gold_d  = gold_q;
    detect  = 1'b0;
    stop    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = APPLY;
          f_d     = '0;
          p_d     = '0;
          mask_d  = '0;
          cov_d   = '0;
          gold_d  = '0;
          cut_d   = inject('0, '0);
        end
      end
      APPLY: state_d = CHECK;
      CHECK: begin
        detect = mismatch;
        if (mismatch) begin
          mask_d[f_q] = 1'b1;
          if (!mask_q[f_q]) cov_d = cov_q + CW'(1);
        end
        // includes a detection made by this very check
        stop = STOP_ON_DETECT && mask_d[f_q];
        if ((p_q < P_LAST) && !stop) begin
          p_d     = p_q + PW'(1);
          state_d = APPLY;
        end else if (f_q < F_LAST) begin
          f_d     = f_q + FW'(1);
          p_d     = '0;
          state_d = APPLY;
        end else begin
          state_d = DONE;
        end
        if (state_d == APPLY) begin
          gold_d = p_d[N_IN-1:0];
          cut_d  = inject(p_d[N_IN-1:0], f_d);
        end else begin
          gold_d = '0;
          cut_d  = '0;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      f_q     <= '0;
      p_q     <= '0;
      mask_q  <= '0;
      cov_q   <= '0;
      cut_q   <= '0;
      gold_q  <= '0;
    end else begin
      state_q <= state_d;
      f_q     <= f_d;
      p_q     <= p_d;
      mask_q  <= mask_d;
      cov_q   <= cov_d;
      cut_q   <= cut_d;
      gold_q  <= gold_d;
    end
  end

  assign cut_in         = cut_q;
  assign gold_in        = gold_q;
  assign busy           = (state_q == APPLY) || (state_q == CHECK);
  assign done           = (state_q == DONE);
  assign fault_idx      = f_q;
  assign detect_valid   = detect;
  assign detect_pattern = p_q[N_IN-1:0];
  assign detected_mask  = mask_q;
  assign coverage_cnt   = cov_q;

endmodule

// File: tb/tb_saf_sweep_ctrl.sv
// Scoreboard bench for saf_sweep_ctrl: three configurations (N_IN=2, N_IN=2 with
// stop-on-detect, N_IN=8) checked against hand-computed detection lists.
module tb_saf_sweep_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  typedef struct packed { logic [7:0] f; logic [7:0] p; } det_t;
  typedef struct packed { logic [15:0] mask; logic [7:0] cov; logic [31:0] cycles; } end_t;

  det_t qd_a[$];
  det_t qd_b[$];
  end_t qe_a[$];
  end_t qe_b[$];
  end_t qe_c[$];

  // A: N_IN=2, full sweep; CUT function selected by mode_a (0 xor, 1 and, 2 tied)
  logic       start_a, cut_y_a, gold_y_a, busy_a, done_a, dv_a;
  logic [1:0] cut_in_a, gold_in_a, fidx_a, dpat_a, mode_a;
  logic [3:0] mask_a;
  logic [2:0] cov_a;
  // B: N_IN=2, stop on first detection, XOR CUT
  logic       start_b, cut_y_b, gold_y_b, busy_b, done_b, dv_b;
  logic [1:0] cut_in_b, gold_in_b, fidx_b, dpat_b;
  logic [3:0] mask_b;
  logic [2:0] cov_b;
  // C: N_IN=8, CUT output tied to golden output
  logic        start_c, cut_y_c, gold_y_c, busy_c, done_c, dv_c;
  logic [7:0]  cut_in_c, gold_in_c, dpat_c;
  logic [3:0]  fidx_c;
  logic [15:0] mask_c;
  logic [4:0]  cov_c;

  assign gold_y_a = (mode_a == 2'd1) ? (&gold_in_a) : (^gold_in_a);
  assign cut_y_a  = (mode_a == 2'd2) ? gold_y_a :
                    (mode_a == 2'd1) ? (&cut_in_a) : (^cut_in_a);
  assign gold_y_b = ^gold_in_b;
  assign cut_y_b  = ^cut_in_b;
  assign gold_y_c = ^gold_in_c;
  assign cut_y_c  = gold_y_c;

  saf_sweep_ctrl #(.N_IN(2), .STOP_ON_DETECT(1'b0)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .cut_y(cut_y_a), .gold_y(gold_y_a),
    .cut_in(cut_in_a), .gold_in(gold_in_a), .busy(busy_a), .done(done_a),
    .fault_idx(fidx_a), .detect_valid(dv_a), .detect_pattern(dpat_a),
    .detected_mask(mask_a), .coverage_cnt(cov_a));

  saf_sweep_ctrl #(.N_IN(2), .STOP_ON_DETECT(1'b1)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .cut_y(cut_y_b), .gold_y(gold_y_b),
    .cut_in(cut_in_b), .gold_in(gold_in_b), .busy(busy_b), .done(done_b),
    .fault_idx(fidx_b), .detect_valid(dv_b), .detect_pattern(dpat_b),
    .detected_mask(mask_b), .coverage_cnt(cov_b));

  saf_sweep_ctrl #(.N_IN(8), .STOP_ON_DETECT(1'b0)) u_c (
    .clk(clk), .rst_n(rst_n), .start(start_c), .cut_y(cut_y_c), .gold_y(gold_y_c),
    .cut_in(cut_in_c), .gold_in(gold_in_c), .busy(busy_c), .done(done_c),
    .fault_idx(fidx_c), .detect_valid(dv_c), .detect_pattern(dpat_c),
    .detected_mask(mask_c), .coverage_cnt(cov_c));

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor A: detections, injected stimulus, sweep length, done width
  initial begin
    int unsigned cnt = 0;
    logic bprev = 1'b0, dprev = 1'b0;
    logic [1:0] inj;
    det_t d;
    end_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (busy_a) begin
          inj = gold_in_a;
          for (int i = 0; i < 2; i++) if (i == int'(fidx_a >> 1)) inj[i] = fidx_a[0];
          check("A cut_in injection", 32'(cut_in_a), 32'(inj));
          cnt = bprev ? cnt + 1 : 1;
        end
        if (dv_a) begin
          if (qd_a.size() == 0) check("A unexpected detect", 32'(dv_a), 32'd0);
          else begin
            d = qd_a.pop_front();
            check("A detect fault", 32'(fidx_a), 32'(d.f));
            check("A detect pattern", 32'(dpat_a), 32'(d.p));
          end
        end
        if (done_a) begin
          check("A done width", 32'(dprev), 32'd0);
          check("A detects left", qd_a.size(), 32'd0);
          if (qe_a.size() == 0) check("A unexpected done", 32'(done_a), 32'd0);
          else begin
            e = qe_a.pop_front();
            check("A mask", 32'(mask_a), 32'(e.mask));
            check("A coverage", 32'(cov_a), 32'(e.cov));
            check("A sweep cycles", cnt, e.cycles);
          end
        end
      end
      bprev = busy_a;
      dprev = done_a;
    end
  end

  // Monitor B
  initial begin
    int unsigned cnt = 0;
    logic bprev = 1'b0;
    det_t d;
    end_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (busy_b) cnt = bprev ? cnt + 1 : 1;
        if (dv_b) begin
          if (qd_b.size() == 0) check("B unexpected detect", 32'(dv_b), 32'd0);
          else begin
            d = qd_b.pop_front();
            check("B detect fault", 32'(fidx_b), 32'(d.f));
            check("B detect pattern", 32'(dpat_b), 32'(d.p));
          end
        end
        if (done_b) begin
          check("B detects left", qd_b.size(), 32'd0);
          if (qe_b.size() == 0) check("B unexpected done", 32'(done_b), 32'd0);
          else begin
            e = qe_b.pop_front();
            check("B mask", 32'(mask_b), 32'(e.mask));
            check("B coverage", 32'(cov_b), 32'(e.cov));
            check("B sweep cycles", cnt, e.cycles);
          end
        end
      end
      bprev = busy_b;
    end
  end

  // Monitor C
  initial begin
    int unsigned cnt = 0;
    logic bprev = 1'b0;
    end_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (busy_c) cnt = bprev ? cnt + 1 : 1;
        if (dv_c) check("C unexpected detect", 32'(dv_c), 32'd0);
        if (done_c) begin
          if (qe_c.size() == 0) check("C unexpected done", 32'(done_c), 32'd0);
          else begin
            e = qe_c.pop_front();
            check("C mask", 32'(mask_c), 32'(e.mask));
            check("C coverage", 32'(cov_c), 32'(e.cov));
            check("C sweep cycles", cnt, e.cycles);
          end
        end
      end
      bprev = busy_c;
    end
  end

  task automatic pulse_start(input int unsigned which);
    @(negedge clk);
    case (which)
      0: start_a = 1'b1;
      1: start_b = 1'b1;
      default: start_c = 1'b1;
    endcase
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    start_c = 1'b0;
  endtask

  task automatic wait_done(input int unsigned which, input int unsigned budget);
    logic seen = 1'b0;
    for (int unsigned i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      case (which)
        0: seen = done_a;
        1: seen = done_b;
        default: seen = done_c;
      endcase
    end
    check("done within budget", 32'(seen), 32'd1);
    @(negedge clk);
  endtask

  task automatic check_zero_a(input string tag);
    check({tag, " busy"}, 32'(busy_a), 32'd0);
    check({tag, " done"}, 32'(done_a), 32'd0);
    check({tag, " detect_valid"}, 32'(dv_a), 32'd0);
    check({tag, " cut_in"}, 32'(cut_in_a), 32'd0);
    check({tag, " gold_in"}, 32'(gold_in_a), 32'd0);
    check({tag, " fault_idx"}, 32'(fidx_a), 32'd0);
    check({tag, " mask"}, 32'(mask_a), 32'd0);
    check({tag, " coverage"}, 32'(cov_a), 32'd0);
  endtask

  task automatic push_xor_a();
    qd_a.push_back('{f: 8'd0, p: 8'd1}); qd_a.push_back('{f: 8'd0, p: 8'd3});
    qd_a.push_back('{f: 8'd1, p: 8'd0}); qd_a.push_back('{f: 8'd1, p: 8'd2});
    qd_a.push_back('{f: 8'd2, p: 8'd2}); qd_a.push_back('{f: 8'd2, p: 8'd3});
    qd_a.push_back('{f: 8'd3, p: 8'd0}); qd_a.push_back('{f: 8'd3, p: 8'd1});
    qe_a.push_back('{mask: 16'hF, cov: 8'd4, cycles: 32'd32});
  endtask

  initial begin
    logic found;
    rst_n = 1'b0;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    mode_a = 2'd0;
    repeat (3) @(negedge clk);
    check_zero_a("reset");
    check("reset C busy", 32'(busy_c), 32'd0);
    rst_n = 1'b1;

    // XOR CUT, full sweep
    push_xor_a();
    pulse_start(0);
    wait_done(0, 100);
    check("idle cut_in", 32'(cut_in_a), 32'd0);
    check("idle gold_in", 32'(gold_in_a), 32'd0);

    // XOR CUT, stop on first detection
    qd_b.push_back('{f: 8'd0, p: 8'd1}); qd_b.push_back('{f: 8'd1, p: 8'd0});
    qd_b.push_back('{f: 8'd2, p: 8'd2}); qd_b.push_back('{f: 8'd3, p: 8'd0});
    qe_b.push_back('{mask: 16'hF, cov: 8'd4, cycles: 32'd14});
    pulse_start(1);
    wait_done(1, 100);

    // AND CUT, with a stray start mid-sweep
    mode_a = 2'd1;
    qd_a.push_back('{f: 8'd0, p: 8'd3}); qd_a.push_back('{f: 8'd1, p: 8'd2});
    qd_a.push_back('{f: 8'd2, p: 8'd3}); qd_a.push_back('{f: 8'd3, p: 8'd1});
    qe_a.push_back('{mask: 16'hF, cov: 8'd4, cycles: 32'd32});
    pulse_start(0);
    repeat (5) @(negedge clk);
    pulse_start(0);
    wait_done(0, 100);

    // Tied CUT: nothing detectable, same sweep length
    mode_a = 2'd2;
    qe_a.push_back('{mask: 16'h0, cov: 8'd0, cycles: 32'd32});
    pulse_start(0);
    wait_done(0, 100);

    // Reset during fault 2, then a clean rerun
    mode_a = 2'd0;
    qd_a.push_back('{f: 8'd0, p: 8'd1}); qd_a.push_back('{f: 8'd0, p: 8'd3});
    qd_a.push_back('{f: 8'd1, p: 8'd0}); qd_a.push_back('{f: 8'd1, p: 8'd2});
    pulse_start(0);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      found = busy_a && (fidx_a == 2'd2);
    end
    check("reached fault 2", 32'(found), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check_zero_a("mid reset");
    check("mid reset detects left", qd_a.size(), 32'd0);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    push_xor_a();
    pulse_start(0);
    wait_done(0, 100);

    // N_IN=8 sweep with a stray start while busy
    qe_c.push_back('{mask: 16'h0, cov: 8'd0, cycles: 32'd8192});
    pulse_start(2);
    repeat (100) @(negedge clk);
    pulse_start(2);
    wait_done(2, 9000);
    check("C idle busy", 32'(busy_c), 32'd0);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
